// File: rtl/uart_pkg.sv
// Shared definitions for the UART register port and its bus-master sequencer.
// Default register map is common with the UART component itself.
package uart_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        POLL_RD,
        POLL_WAIT,
        GAP,
        WRITE,
        DONE
    } SeqState;

    localparam logic [2:0] UART_ADDR_STATUS = 3'd1;
    localparam logic [2:0] UART_ADDR_TX     = 3'd2;

endpackage

// File: rtl/mmio_tx_sequencer.sv
// Bus-master sequencer: holds the UART in reset, then streams MSG_LEN bytes
// to its TX register, polling STATUS before every byte.
module mmio_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int RESET_CYCLES = 16,
    parameter int MSG_LEN      = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(UART_ADDR_STATUS),
    parameter logic [ADDR_WIDTH-1:0] ADDR_TX     = ADDR_WIDTH'(UART_ADDR_TX),
    parameter int TX_BUSY_BIT  = 0,
    parameter int POLL_GAP     = 2,
    localparam int IDX_W = $clog2(MSG_LEN + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [IDX_W-1:0]      msg_idx_o,
    input  logic [DATA_WIDTH-1:0] msg_data_i,
    output logic                  dev_reset_o,
    output logic                  rd_o,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o
);

    localparam int CNT_MAX = (RESET_CYCLES > POLL_GAP) ? RESET_CYCLES : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    SeqState state, state_n;

    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx_n;
    logic                  dev_reset_n;
    logic                  rd_n;
    logic                  wr_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  aborted_n;
    logic                  status_busy;

    // Only the busy flag matters; the other STATUS bits are deliberately ignored.
    logic unused_rdata;
    assign unused_rdata = ^rdata_i;
    assign status_busy  = rdata_i[TX_BUSY_BIT];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = msg_idx_o;
        aborted_n = 1'b0;

        if (abort_i && state != RST_HOLD && state != IDLE) begin
            state_n   = IDLE;
            idx_n     = '0;
            aborted_n = 1'b1;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start_i) begin
                        state_n = POLL_RD;
                        idx_n   = '0;
                    end
                end
                POLL_RD: state_n = POLL_WAIT;
                POLL_WAIT: begin
                    if (!status_busy) begin
                        state_n = WRITE;
                    end else if (POLL_GAP == 0) begin
                        state_n = POLL_RD;
                    end else begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = POLL_RD;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (msg_idx_o == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = msg_idx_o + 1'b1;
                        state_n = POLL_RD;
                    end
                end
                DONE: state_n = IDLE;
                default: state_n = RST_HOLD;
            endcase
        end

        // Outputs are decoded from the next state so they appear registered.
        dev_reset_n = (state_n == RST_HOLD);
        rd_n        = (state_n == POLL_RD);
        wr_n        = (state_n == WRITE);
        done_n      = (state_n == DONE);
        busy_n      = (state_n == POLL_RD) || (state_n == POLL_WAIT)
                   || (state_n == GAP) || (state_n == WRITE);
        addr_n      = addr_o;
        wdata_n     = wdata_o;
        if (state_n == POLL_RD) begin
            addr_n = ADDR_STATUS;
        end
        if (state_n == WRITE) begin
            addr_n  = ADDR_TX;
            wdata_n = msg_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RST_HOLD;
            cnt         <= '0;
            msg_idx_o   <= '0;
            dev_reset_o <= 1'b1;
            rd_o        <= 1'b0;
            wr_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            aborted_o   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            msg_idx_o   <= idx_n;
            dev_reset_o <= dev_reset_n;
            rd_o        <= rd_n;
            wr_o        <= wr_n;
            addr_o      <= addr_n;
            wdata_o     <= wdata_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            aborted_o   <= aborted_n;
        end
    end

endmodule

// File: tb/tb_mmio_tx_sequencer.sv
// Bench for mmio_tx_sequencer: scripted UART status responses, bus event log
// compared against a cycle schedule derived from the poll/write timing rules.
module tb_mmio_tx_sequencer;

    localparam int DW       = 8;
    localparam int AW       = 3;
    localparam int RST_CYC  = 16;
    localparam int MLEN     = 4;
    localparam int POLL_GAP = 2;
    localparam int IDX_W    = $clog2(MLEN + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [IDX_W-1:0] msg_idx_o;
    logic [DW-1:0]    msg_data_i;
    logic             dev_reset_o;
    logic             rd_o;
    logic             wr_o;
    logic [AW-1:0]    addr_o;
    logic [DW-1:0]    wdata_o;
    logic [DW-1:0]    rdata_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;

    mmio_tx_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_CYCLES(RST_CYC),
        .MSG_LEN(MLEN), .ADDR_STATUS(3'd1), .ADDR_TX(3'd2),
        .TX_BUSY_BIT(0), .POLL_GAP(POLL_GAP)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .msg_idx_o(msg_idx_o), .msg_data_i(msg_data_i),
        .dev_reset_o(dev_reset_o), .rd_o(rd_o), .wr_o(wr_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] rom [8];
    bit         plan [$];
    int         bc [MLEN];
    int         rd_t [$];
    logic [2:0] rd_a [$];
    int         wr_t [$];
    logic [2:0] wr_a [$];
    logic [7:0] wr_d [$];
    int         done_t [$];
    int         ab_t [$];
    bit         rd_prev = 1'b0;
    bit         wr_prev = 1'b0;

    assign msg_data_i = rom[msg_idx_o];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and UART STATUS responder.
    always @(negedge clock) begin
        if (!reset) begin
            vectors++;
            assert (!(rd_o && wr_o) && !(rd_o && rd_prev) && !(wr_o && wr_prev)) else begin
                miscompares++;
                $error("FAIL strobe_rule observed=%0d%0d expected=no overlap", rd_o, wr_o);
            end
        end
        if (rd_o === 1'b1) begin
            rd_t.push_back(cyc);
            rd_a.push_back(addr_o);
            rdata_i = DW'($urandom);
            rdata_i[0] = (plan.size() > 0) ? plan.pop_front() : 1'b0;
        end else if (!rd_prev) begin
            rdata_i = DW'($urandom) | 8'h01;
        end
        if (wr_o === 1'b1) begin
            wr_t.push_back(cyc);
            wr_a.push_back(addr_o);
            wr_d.push_back(wdata_o);
        end
        if (done_o === 1'b1) done_t.push_back(cyc);
        if (aborted_o === 1'b1) ab_t.push_back(cyc);
        rd_prev = (rd_o === 1'b1);
        wr_prev = (wr_o === 1'b1);
    end

    task automatic clear_logs();
        rd_t.delete(); rd_a.delete();
        wr_t.delete(); wr_a.delete(); wr_d.delete();
        done_t.delete(); ab_t.delete();
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b1;
        @(negedge clock);
        check("rst_rd", rd_o, 0);
        check("rst_wr", wr_o, 0);
        check("rst_dev", dev_reset_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_abrt", aborted_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_idx", msg_idx_o, 0);
        repeat (2) @(negedge clock);
        clear_logs();
        plan.delete();
        reset = 1'b0;
        n = 0;
        while (dev_reset_o === 1'b1 && n < 100) begin
            start_i = (n == 5);
            abort_i = (n == 7);
            n++;
            @(negedge clock);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        check("dev_reset_len", n, RST_CYC);
        repeat (4) @(negedge clock);
        check("hold_no_rd", rd_t.size(), 0);
        check("hold_no_wr", wr_t.size(), 0);
        check("hold_no_abrt", ab_t.size(), 0);
        check("hold_busy", busy_o, 0);
    endtask

    // ab_mode: 0 = no abort, <0 = random abort cycle, >0 = abort offset from start
    task automatic run_xfer(input bit ascii, input int ab_mode);
        int s, r, d, a, st, len, nr, nw;
        int exp_rd [$];
        int exp_wr [$];
        logic [7:0] exp_d [$];
        for (int k = 0; k < MLEN; k++) rom[k] = ascii ? 8'(8'h41 + k) : 8'($urandom);
        plan.delete();
        for (int k = 0; k < MLEN; k++) begin
            repeat (bc[k]) plan.push_back(1'b1);
            plan.push_back(1'b0);
        end
        clear_logs();
        @(negedge clock);
        abort_i = 1'b1;
        @(negedge clock);
        abort_i = 1'($urandom);
        start_i = 1'b1;
        s = cyc;
        r = s + 1;
        for (int k = 0; k < MLEN; k++) begin
            repeat (bc[k]) begin
                exp_rd.push_back(r);
                r += 2 + POLL_GAP;
            end
            exp_rd.push_back(r);
            exp_wr.push_back(r + 2);
            exp_d.push_back(rom[k]);
            r += 3;
        end
        d = exp_wr[MLEN-1] + 1;
        a = (ab_mode < 0) ? s + $urandom_range(1, d - s - 1) :
            (ab_mode > 0) ? s + ab_mode : -1;
        st = s + 1 + $urandom_range(0, ((a > 0) ? a : d) - s - 1);
        len = d + 4 - s;
        for (int i = 1; i <= len; i++) begin
            @(negedge clock);
            start_i = (cyc == st);
            abort_i = (cyc == a);
            check("busy", busy_o, (a > 0) ? (cyc > s && cyc <= a) : (cyc > s && cyc < d));
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        nr = 0;
        nw = 0;
        foreach (exp_rd[i]) if (a < 0 || exp_rd[i] <= a) nr++;
        foreach (exp_wr[i]) if (a < 0 || exp_wr[i] <= a) nw++;
        check("rd_count", rd_t.size(), nr);
        check("wr_count", wr_t.size(), nw);
        for (int i = 0; i < nr && i < rd_t.size(); i++) begin
            check("rd_cycle", rd_t[i] - s, exp_rd[i] - s);
            check("rd_addr", rd_a[i], 3'd1);
        end
        for (int i = 0; i < nw && i < wr_t.size(); i++) begin
            check("wr_cycle", wr_t[i] - s, exp_wr[i] - s);
            check("wr_addr", wr_a[i], 3'd2);
            check("wr_data", wr_d[i], exp_d[i]);
        end
        check("done_count", done_t.size(), (a > 0) ? 0 : 1);
        check("abort_count", ab_t.size(), (a > 0) ? 1 : 0);
        if (a < 0 && done_t.size() > 0) check("done_cycle", done_t[0] - s, d - s);
        if (a > 0 && ab_t.size() > 0) check("abort_cycle", ab_t[0] - s, a + 1 - s);
        if (a > 0) check("abort_idx", msg_idx_o, 0);
    endtask

    initial begin
        do_reset();

        bc = '{0, 0, 0, 0};
        run_xfer(1'b1, 0);

        bc = '{0, 0, 3, 0};
        run_xfer(1'b0, 0);

        bc = '{0, 0, 0, 0};
        run_xfer(1'b0, 7);
        run_xfer(1'b1, 0);

        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < MLEN; k++) bc[k] = $urandom_range(0, 3);
            run_xfer(1'b0, (t % 3 == 2) ? -1 : 0);
        end

        @(negedge clock);
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        @(negedge clock);
        check("pre_reset_busy", busy_o, 1);
        do_reset();

        bc = '{1, 0, 2, 0};
        run_xfer(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
